fp_vec_checker: RTL and testbench

//  Synthesizable self-check engine on the fp_unit execute port (BIST/FPGA bring-up).
//  - Consumes a valid/ready stream of test vectors: operands, control and expected result/flags.
//  - Issues one operation at a time to fp_unit and waits for its ready.
//  - Compares the returned result and flags against the expected values.
//  - Counts passes and captures the first mismatch for host readout.

---
 rtl/fp_vec_checker_pkg.sv | 94 +++++++++
 rtl/fp_vec_checker.sv | 145 ++++++++++++++
 tb/tb_fp_vec_checker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_vec_checker_pkg.sv
// fp_vec_checker_pkg
//   Shared types for the fp_unit execute port and the vector checker that
//   drives it: operation decode, execute request/response, test vector,
//   captured failure record, checker state enum and the result compare rule.
package fp_vec_checker_pkg;

  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmsub;
    logic       fnmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  localparam logic [31:0] QNAN_F32 = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic [31:0]      exp_result;
    logic [4:0]       exp_flags;
    logic             last;
  } fp_vec_t;

  typedef struct packed {
    fp_vec_t     vec;
    logic [31:0] calc_result;
    logic [4:0]  calc_flags;
    logic        tmo;
  } fp_fail_t;

  typedef enum logic [2:0] {
    CHK_IDLE,
    CHK_ISSUE,
    CHK_WAIT,
    CHK_CHECK,
    CHK_DONE,
    CHK_FAIL
  } fp_chk_state_t;

  // Returns 1 on mismatch. A canonical quiet NaN from an arithmetic op is
  // accepted against any expected quiet NaN (only exponent and quiet bit are
  // compared). Compares and float->int converts produce integer results, so
  // they always use the full 32-bit compare.
  function automatic logic fp_chk_cmp(input fp_vec_t     v,
                                      input logic [31:0] calc_result,
                                      input logic [4:0]  calc_flags,
                                      input logic        tmo);
    logic flag_mis;
    logic res_mis;
    flag_mis = |(v.exp_flags ^ calc_flags);
    if (!v.op.fcmp && !v.op.fcvt_f2i && (calc_result == QNAN_F32))
      res_mis = (v.exp_result[30:22] != calc_result[30:22]);
    else
      res_mis = (v.exp_result != calc_result);
    return res_mis | flag_mis | tmo;
  endfunction

endpackage

// File: rtl/fp_vec_checker.sv
// fp_vec_checker
//   Self-check engine sitting on the fp_unit execute port. Accepts test
//   vectors on a valid/ready stream, issues each one to fp_unit, waits for
//   the response (or a timeout), compares result and flags against the
//   expected values, counts passes/failures and records the first failure.
// Ports
//   clock, reset      clock; synchronous active-low reset
//   vec_valid/ready   test vector stream handshake
//   vec               operands, control, expected result/flags, last marker
//   exe_req / exe_rsp execute request to / response from fp_unit
//   pass_cnt/fail_cnt saturating counters
//   done, fail        sticky status
//   fail_info         first failing vector with calculated result/flags
//
// state     | meaning
// ----------+---------------------------------------------------------
// CHK_IDLE  | ready for a vector (vec_ready=1)
// CHK_ISSUE | one-cycle enable pulse to fp_unit, timeout timer loaded
// CHK_WAIT  | operands held, waiting for exe_rsp.ready or timeout
// CHK_CHECK | compare and update counters / failure record
// CHK_DONE  | last vector checked; terminal until reset
// CHK_FAIL  | stopped on first failure; terminal until reset
module fp_vec_checker
  import fp_vec_checker_pkg::*;
#(
  parameter int TIMEOUT      = 64,
  parameter int STOP_ON_FAIL = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  fp_vec_t          vec,
  output fp_exe_in_type    exe_req,
  input  fp_exe_out_type   exe_rsp,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             done,
  output logic             fail,
  output fp_fail_t         fail_info
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fp_chk_state_t state, state_next;

  fp_vec_t           hold_vec;
  logic [31:0]       calc_result;
  logic [4:0]        calc_flags;
  logic              tmo_flag;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              mis;

  assign mis = fp_chk_cmp(hold_vec, calc_result, calc_flags, tmo_flag);

  always_ff @(posedge clock) begin
    if (!reset) state <= CHK_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CHK_IDLE:  if (vec_valid) state_next = CHK_ISSUE;
      CHK_ISSUE: state_next = CHK_WAIT;
      // ready is tested first so a response on the terminal-count cycle counts
      CHK_WAIT:  if (exe_rsp.ready || (tmo_cnt == '0)) state_next = CHK_CHECK;
      CHK_CHECK: begin
        if (mis && (STOP_ON_FAIL != 0)) state_next = CHK_FAIL;
        else if (hold_vec.last)         state_next = CHK_DONE;
        else                            state_next = CHK_IDLE;
      end
      default:   state_next = state;
    endcase
  end

  always_comb begin
    vec_ready = 1'b0;
    exe_req   = '0;
    exe_req.op = init_fp_operation;
    case (state)
      CHK_IDLE: vec_ready = reset;
      CHK_ISSUE, CHK_WAIT: begin
        exe_req.data1  = hold_vec.data1;
        exe_req.data2  = hold_vec.data2;
        exe_req.data3  = hold_vec.data3;
        exe_req.fmt    = hold_vec.fmt;
        exe_req.rm     = hold_vec.rm;
        exe_req.op     = hold_vec.op;
        exe_req.enable = (state == CHK_ISSUE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_vec    <= '0;
      calc_result <= '0;
      calc_flags  <= '0;
      tmo_flag    <= 1'b0;
      tmo_cnt     <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_info   <= '0;
    end else begin
      case (state)
        CHK_IDLE: if (vec_valid) hold_vec <= vec;
        CHK_ISSUE: begin
          tmo_cnt  <= TMO_W'(TIMEOUT - 1);
          tmo_flag <= 1'b0;
        end
        CHK_WAIT: begin
          if (exe_rsp.ready) begin
            calc_result <= exe_rsp.result;
            calc_flags  <= exe_rsp.flags;
          end else if (tmo_cnt == '0) begin
            // nothing came back; record an all-zero result alongside tmo
            calc_result <= '0;
            calc_flags  <= '0;
            tmo_flag    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        CHK_CHECK: begin
          if (mis) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            fail <= 1'b1;
            if (!fail) fail_info <= '{vec: hold_vec, calc_result: calc_result,
                                      calc_flags: calc_flags, tmo: tmo_flag};
          end else begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
          end
          if (state_next == CHK_DONE) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_vec_checker.sv
// Directed bench for fp_vec_checker. Instance a runs with STOP_ON_FAIL=0,
// instance b with STOP_ON_FAIL=1. Each has a small fp_unit stub that returns
// a programmed result/flags a fixed number of cycles after the enable pulse.
module tb_fp_vec_checker;
  import fp_vec_checker_pkg::*;

  localparam int TMO = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- instance a (continue on failure)
  logic           a_vec_valid = 1'b0;
  logic           a_vec_ready;
  fp_vec_t        a_vec = '0;
  fp_exe_in_type  a_req;
  fp_exe_out_type a_rsp = '0;
  logic [31:0]    a_pass, a_fcnt;
  logic           a_done, a_fail;
  fp_fail_t       a_info;

  fp_vec_checker #(.TIMEOUT(TMO), .STOP_ON_FAIL(0), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset),
    .vec_valid(a_vec_valid), .vec_ready(a_vec_ready), .vec(a_vec),
    .exe_req(a_req), .exe_rsp(a_rsp),
    .pass_cnt(a_pass), .fail_cnt(a_fcnt),
    .done(a_done), .fail(a_fail), .fail_info(a_info)
  );

  // stub: ready shows up a_lat+1 cycles after the issue cycle
  int          a_lat  = 1;
  logic        a_mute = 1'b0;
  logic [31:0] a_res  = '0;
  logic [4:0]  a_flg  = '0;
  int          a_pend = 0;
  always @(posedge clock) begin
    a_rsp.ready  <= 1'b0;
    a_rsp.result <= 32'hDEAD_BEEF;
    a_rsp.flags  <= 5'h1F;
    if (a_pend > 0) begin
      a_pend <= a_pend - 1;
      if (a_pend == 1) begin
        a_rsp.ready  <= 1'b1;
        a_rsp.result <= a_res;
        a_rsp.flags  <= a_flg;
      end
    end
    if (a_req.enable && !a_mute) a_pend <= a_lat;
  end

  int a_issue_t[$];
  always @(negedge clock) if (a_req.enable) a_issue_t.push_back(cyc);

  // ---------------- instance b (stop on failure)
  logic           b_vec_valid = 1'b0;
  logic           b_vec_ready;
  fp_vec_t        b_vec = '0;
  fp_exe_in_type  b_req;
  fp_exe_out_type b_rsp = '0;
  logic [31:0]    b_pass, b_fcnt;
  logic           b_done, b_fail;
  fp_fail_t       b_info;

  fp_vec_checker #(.TIMEOUT(TMO), .STOP_ON_FAIL(1), .CNT_W(32)) dut_b (
    .clock(clock), .reset(reset),
    .vec_valid(b_vec_valid), .vec_ready(b_vec_ready), .vec(b_vec),
    .exe_req(b_req), .exe_rsp(b_rsp),
    .pass_cnt(b_pass), .fail_cnt(b_fcnt),
    .done(b_done), .fail(b_fail), .fail_info(b_info)
  );

  logic [31:0] b_res = 32'h4000_0000;
  int          b_pend = 0;
  always @(posedge clock) begin
    b_rsp.ready  <= 1'b0;
    b_rsp.result <= 32'hDEAD_BEEF;
    b_rsp.flags  <= 5'h1F;
    if (b_pend > 0) begin
      b_pend <= b_pend - 1;
      if (b_pend == 1) begin
        b_rsp.ready  <= 1'b1;
        b_rsp.result <= b_res;
        b_rsp.flags  <= 5'h00;
      end
    end
    if (b_req.enable) b_pend <= 1;
  end

  // ---------------- helpers
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic fp_vec_t mk(input fp_operation_type op, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] er,
                                 input logic [4:0] ef, input logic last);
    fp_vec_t v;
    v = '0;
    v.op = op; v.data1 = d1; v.data2 = d2;
    v.exp_result = er; v.exp_flags = ef; v.last = last;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; a_vec_valid = 1'b0; b_vec_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // called at a negedge; returns at the negedge of the ISSUE cycle
  task automatic send_a(input fp_vec_t v);
    int n;
    n = 0;
    a_vec = v; a_vec_valid = 1'b1;
    while (!a_vec_ready && n < 200) begin @(negedge clock); n++; end
    if (!a_vec_ready) check("a_handshake_timeout", 64'(0), 64'(1));
    @(negedge clock);
    a_vec_valid = 1'b0;
  endtask

  task automatic wait_a_done();
    int n;
    n = 0;
    while (!a_done && n < 300) begin @(negedge clock); n++; end
    if (!a_done) check("a_done_timeout", 64'(0), 64'(1));
  endtask

  fp_operation_type op_add, op_cvt, op_sqrt;

  initial begin
    int n;
    op_add  = init_fp_operation; op_add.fadd      = 1'b1;
    op_cvt  = init_fp_operation; op_cvt.fcvt_f2i  = 1'b1;
    op_sqrt = init_fp_operation; op_sqrt.fsqrt    = 1'b1;

    // reset values while reset is held low
    repeat (2) @(negedge clock);
    check("rst_vec_ready", 64'(a_vec_ready), 64'(0));
    check("rst_pass_cnt",  64'(a_pass), 64'(0));
    check("rst_fail_cnt",  64'(a_fcnt), 64'(0));
    check("rst_done_fail", 64'({a_done, a_fail}), 64'(0));
    check("rst_fail_info", 64'(|a_info), 64'(0));
    check("rst_exe_req",   64'(|a_req), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    check("idle_vec_ready", 64'(a_vec_ready), 64'(1));

    // instance b: first failure halts it in FAIL
    b_vec = mk(op_add, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0001, 5'h00, 1'b0);
    b_vec_valid = 1'b1;
    n = 0;
    while (!b_vec_ready && n < 20) begin @(negedge clock); n++; end
    @(negedge clock);
    b_vec = mk(op_add, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5'h00, 1'b1);
    n = 0;
    while (!b_fail && n < 50) begin @(negedge clock); n++; end
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (b_vec_ready || b_req.enable) n++;
    end
    b_vec_valid = 1'b0;
    check("stop_fail",         64'(b_fail), 64'(1));
    check("stop_fail_cnt",     64'(b_fcnt), 64'(1));
    check("stop_pass_cnt",     64'(b_pass), 64'(0));
    check("stop_no_accept",    64'(n), 64'(0));
    check("stop_done",         64'(b_done), 64'(0));
    check("stop_info_exp",     64'(b_info.vec.exp_result), 64'(32'h4000_0001));

    // fadd 1.0 + 1.0
    a_lat = 1; a_res = 32'h4000_0000; a_flg = 5'h00;
    send_a(mk(op_add, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5'h00, 1'b1));
    check("fadd_issue_data1", 64'(a_req.data1), 64'(32'h3F80_0000));
    wait_a_done();
    check("fadd_pass_cnt", 64'(a_pass), 64'(1));
    check("fadd_fail_cnt", 64'(a_fcnt), 64'(0));
    check("fadd_done",     64'(a_done), 64'(1));
    check("fadd_fail",     64'(a_fail), 64'(0));
    check("done_no_ready", 64'(a_vec_ready), 64'(0));

    // f32_to_i32 of qNaN: pass, then wrong expected flags
    do_reset();
    a_res = 32'h7FFF_FFFF; a_flg = 5'h10;
    send_a(mk(op_cvt, 32'h7FC0_0000, 32'h0, 32'h7FFF_FFFF, 5'h10, 1'b0));
    send_a(mk(op_cvt, 32'h7FC0_0000, 32'h0, 32'h7FFF_FFFF, 5'h00, 1'b1));
    wait_a_done();
    check("cvt_pass_cnt",    64'(a_pass), 64'(1));
    check("cvt_fail_cnt",    64'(a_fcnt), 64'(1));
    check("cvt_fail",        64'(a_fail), 64'(1));
    check("cvt_calc_flags",  64'(a_info.calc_flags), 64'(5'h10));
    check("cvt_info_expflg", 64'(a_info.vec.exp_flags), 64'(5'h00));

    // fsqrt(-1): relaxed qNaN compare, then a non-NaN expectation
    do_reset();
    a_res = 32'h7FC0_0000; a_flg = 5'h10;
    send_a(mk(op_sqrt, 32'hBF80_0000, 32'h0, 32'h7FC0_0001, 5'h10, 1'b0));
    send_a(mk(op_sqrt, 32'hBF80_0000, 32'h0, 32'h7F80_0000, 5'h10, 1'b1));
    wait_a_done();
    check("sqrt_pass_cnt", 64'(a_pass), 64'(1));
    check("sqrt_fail_cnt", 64'(a_fcnt), 64'(1));
    check("sqrt_info_exp", 64'(a_info.vec.exp_result), 64'(32'h7F80_0000));
    check("sqrt_info_calc", 64'(a_info.calc_result), 64'(32'h7FC0_0000));

    // timeout: ISSUE, 64 WAIT cycles, CHECK, then fail is visible
    do_reset();
    a_mute = 1'b1;
    send_a(mk(op_add, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5'h00, 1'b1));
    check("tmo_issue_enable", 64'(a_req.enable), 64'(1));
    n = 0;
    while (!a_fail && n < 200) begin @(negedge clock); n++; end
    check("tmo_latency", 64'(n), 64'(TMO + 2));
    check("tmo_bit",     64'(a_info.tmo), 64'(1));
    check("tmo_fail_cnt", 64'(a_fcnt), 64'(1));
    a_mute = 1'b0;
    wait_a_done();

    // five back-to-back vectors, the second one wrong
    do_reset();
    a_lat = 1; a_res = 32'h4000_0000; a_flg = 5'h00;
    a_issue_t.delete();
    for (int i = 0; i < 5; i++)
      send_a(mk(op_add, 32'(i), 32'h3F80_0000,
                (i == 1) ? 32'h4000_0001 : 32'h4000_0000, 5'h00, i == 4));
    wait_a_done();
    check("seq_pass_cnt",   64'(a_pass), 64'(4));
    check("seq_fail_cnt",   64'(a_fcnt), 64'(1));
    check("seq_done",       64'(a_done), 64'(1));
    check("seq_info_data1", 64'(a_info.vec.data1), 64'(1));
    check("seq_info_exp",   64'(a_info.vec.exp_result), 64'(32'h4000_0001));
    // stub response arrives a_lat+1 cycles after issue, so spacing is 3+(a_lat+1)
    if (a_issue_t.size() >= 3)
      check("seq_throughput", 64'(a_issue_t[2] - a_issue_t[1]), 64'(3 + a_lat + 1));
    else
      check("seq_issue_count", 64'(a_issue_t.size()), 64'(5));

    // reset during WAIT, response arrives after reset releases
    do_reset();
    a_lat = 2;
    send_a(mk(op_add, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5'h00, 1'b1));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rstw_late_ready", 64'(a_rsp.ready), 64'(1));
    repeat (3) @(negedge clock);
    check("rstw_pass_cnt",  64'(a_pass), 64'(0));
    check("rstw_fail_cnt",  64'(a_fcnt), 64'(0));
    check("rstw_done_fail", 64'({a_done, a_fail}), 64'(0));
    check("rstw_idle",      64'(a_vec_ready), 64'(1));
    check("rstw_req",       64'(|a_req), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "global timeout");
  end

endmodule
